// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN streaming stages.
//   clog2_min1   : $clog2 that never returns 0, so that 1-entry dimensions
//                  still get a 1-bit counter/port.
//   chw_to_index : linear element index for (channel,row,col) in the
//                  flatten ordering (col fastest, then row, then channel).
//   stream_state_t : state encoding of the element streaming FSMs.
package cnn_pkg;

   localparam int DATA_WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } stream_state_t;

   function automatic int clog2_min1(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

   function automatic int chw_to_index(input int channel, input int row,
                                       input int col, input int width);
      return (channel * width + row) * width + col;
   endfunction

endpackage

// File: rtl/chw_counter.sv
// Nested channel/row/col wrap counter over a square WIDTH x WIDTH map with
// CHANNELS planes. col advances fastest, then row, then channel.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (counters -> 0)
//   clear     : synchronous return to (0,0,0); has priority over inc
//   inc       : advance one element
//   channel   : current channel coordinate
//   row, col  : current spatial coordinates
//   last      : current position is the final element of the map
module chw_counter
   import cnn_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 2,
   parameter int CW       = clog2_min1(CHANNELS),
   parameter int RW       = clog2_min1(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          inc,
   output logic [CW-1:0] channel,
   output logic [RW-1:0] row,
   output logic [RW-1:0] col,
   output logic          last
);

   localparam logic [RW-1:0] POS_MAX = RW'(WIDTH - 1);
   localparam logic [CW-1:0] CH_MAX  = CW'(CHANNELS - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         channel <= '0;
         row     <= '0;
         col     <= '0;
      end else if (clear) begin
         channel <= '0;
         row     <= '0;
         col     <= '0;
      end else if (inc) begin
         if (col == POS_MAX) begin
            col <= '0;
            if (row == POS_MAX) begin
               row     <= '0;
               channel <= (channel == CH_MAX) ? '0 : channel + 1'b1;
            end else begin
               row <= row + 1'b1;
            end
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   assign last = (col == POS_MAX) && (row == POS_MAX) && (channel == CH_MAX);

endmodule

// File: rtl/unflatten_stream.sv
// Latches a flat vector of IN_CHANNELS x IN_WIDTH x IN_WIDTH elements and
// replays it as one element per valid/ready beat, tagged with coordinates.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : latch in_vector and begin streaming (only honoured in IDLE)
//   in_vector    : flat vector, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy         : high while streaming and during the done cycle
//   done         : one-cycle pulse after the final beat was accepted
//   out_valid    : element available
//   out_ready    : consumer accepts the element
//   out_data     : current element
//   out_channel, out_row, out_col : coordinates of the current element
//   out_last     : current element is the final one of the frame
// Handshake: a beat transfers on a rising edge where out_valid & out_ready.
// While out_valid is high and out_ready low, data/coords/last hold steady.
// out_ready has no combinational path to out_valid.
module unflatten_stream
   import cnn_pkg::*;
#(
   parameter int IN_WIDTH    = 4,
   parameter int IN_CHANNELS = 2,
   parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
   localparam int NUM_ELEMS  = IN_WIDTH * IN_WIDTH * IN_CHANNELS,
   localparam int VEC_WIDTH  = NUM_ELEMS * DATA_WIDTH,
   localparam int CW         = clog2_min1(IN_CHANNELS),
   localparam int RW         = clog2_min1(IN_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [VEC_WIDTH-1:0]  in_vector,
   output logic                  busy,
   output logic                  done,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CW-1:0]         out_channel,
   output logic [RW-1:0]         out_row,
   output logic [RW-1:0]         out_col,
   output logic                  out_last
);

   localparam int IW = clog2_min1(NUM_ELEMS);

   stream_state_t        state;
   logic [VEC_WIDTH-1:0] vec_q;
   logic [IW-1:0]        idx;
   logic                 beat;
   logic                 cnt_clear;
   logic                 cnt_inc;
   logic                 cnt_last;

   assign beat      = out_valid && out_ready;
   assign cnt_clear = (state == ST_IDLE) && start;
   // Counters hold on the final beat so the coordinates stay at the last
   // element through DONE.
   assign cnt_inc   = (state == ST_STREAM) && beat && !cnt_last;

   chw_counter #(
      .WIDTH    (IN_WIDTH),
      .CHANNELS (IN_CHANNELS),
      .CW       (CW),
      .RW       (RW)
   ) u_chw (
      .clk     (clk),
      .rst     (rst),
      .clear   (cnt_clear),
      .inc     (cnt_inc),
      .channel (out_channel),
      .row     (out_row),
      .col     (out_col),
      .last    (cnt_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         vec_q     <= '0;
         idx       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  vec_q     <= in_vector;
                  idx       <= '0;
                  busy      <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (beat) begin
                  if (cnt_last) begin
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               out_valid <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   // The linear index runs alongside the coordinates so the element select
   // is a single part-select rather than a multiply of three counters.
   assign out_data = vec_q[int'(idx) * DATA_WIDTH +: DATA_WIDTH];
   assign out_last = out_valid && cnt_last;

endmodule

// File: tb/tb_unflatten_stream.sv
// Directed bench for unflatten_stream: a 4x4x2 instance and a 1x1x1 instance.
module tb_unflatten_stream;

   localparam int W  = 4;
   localparam int C  = 2;
   localparam int DW = 8;
   localparam int N  = W * W * C;
   localparam int VW = N * DW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          start;
   logic [VW-1:0] in_vector;
   logic          busy, done, out_valid, out_ready, out_last;
   logic [DW-1:0] out_data;
   logic [0:0]    out_channel;
   logic [1:0]    out_row, out_col;

   logic          start_d;
   logic [7:0]    vec_d;
   logic          busy_d, done_d, valid_d, ready_d, last_d;
   logic [7:0]    data_d;
   logic [0:0]    ch_d, row_d, col_d;

   unflatten_stream #(.IN_WIDTH(W), .IN_CHANNELS(C), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .in_vector(in_vector),
      .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_channel(out_channel), .out_row(out_row),
      .out_col(out_col), .out_last(out_last)
   );

   unflatten_stream #(.IN_WIDTH(1), .IN_CHANNELS(1), .DATA_WIDTH(8)) dut_deg (
      .clk(clk), .rst(rst), .start(start_d), .in_vector(vec_d),
      .busy(busy_d), .done(done_d), .out_valid(valid_d), .out_ready(ready_d),
      .out_data(data_d), .out_channel(ch_d), .out_row(row_d),
      .out_col(col_d), .out_last(last_d)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // kind 0: element i = i; kind 1: 31-i; kind 2: (7i+3) mod 256
   function automatic logic [7:0] elem(input int kind, input int i);
      case (kind)
         0:       return 8'(i);
         1:       return 8'(31 - i);
         default: return 8'((i * 7 + 3) & 255);
      endcase
   endfunction

   function automatic logic [VW-1:0] make_vec(input int kind);
      logic [VW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = elem(kind, i);
      return v;
   endfunction

   // Starts a frame at the current negedge and checks every presented beat.
   // stall_beat: beat held with out_ready low for 3 cycles (-1 = none).
   // ignore_beat: beat at which a foreign start/vector is driven; also
   // drives start during DONE (-1 = none). Returns negedges from start until
   // the first IDLE cycle after DONE.
   task automatic run_frame(input int kind, input int stall_beat,
                            input int ignore_beat, output int cycles);
      int j, stalls, dones;
      j = 0; stalls = 0; dones = 0;
      in_vector = make_vec(kind);
      start     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      cycles    = 1;
      start     = 1'b0;
      in_vector = ~make_vec(kind);
      while (j < N && cycles < 200) begin
         check("valid", 32'(out_valid), 32'd1);
         check("busy", 32'(busy), 32'd1);
         check("data", 32'(out_data), 32'(elem(kind, j)));
         check("channel", 32'(out_channel), 32'(j / 16));
         check("row", 32'(out_row), 32'((j / 4) % 4));
         check("col", 32'(out_col), 32'(j % 4));
         check("last", 32'(out_last), 32'(j == N - 1));
         if (done) dones++;
         start = (j == ignore_beat);
         if (j == ignore_beat) in_vector = make_vec(2);
         if (j == stall_beat && stalls < 3) begin
            out_ready = 1'b0;
            stalls++;
         end else begin
            out_ready = 1'b1;
            j++;
         end
         @(negedge clk);
         cycles++;
      end
      start = 1'b0;
      check("done_pulse", 32'(done), 32'd1);
      check("busy_in_done", 32'(busy), 32'd1);
      check("valid_in_done", 32'(out_valid), 32'd0);
      if (done) dones++;
      if (ignore_beat >= 0) begin
         start     = 1'b1;
         in_vector = make_vec(2);
      end
      @(negedge clk);
      cycles++;
      start = 1'b0;
      check("done_cleared", 32'(done), 32'd0);
      check("busy_cleared", 32'(busy), 32'd0);
      check("valid_idle", 32'(out_valid), 32'd0);
      check("done_count", 32'(dones), 32'd1);
   endtask

   int cyc;

   initial begin
      rst = 1'b1; start = 1'b0; in_vector = '0; out_ready = 1'b1;
      start_d = 1'b0; vec_d = 8'h00; ready_d = 1'b1;
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_deg_last", 32'(last_d), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Basic frame with start ignored at beat 10 and during DONE
      run_frame(0, -1, 10, cyc);
      check("frame_cycles", 32'(cyc), 32'd34);

      // Backpressure at beat 5
      run_frame(0, 5, -1, cyc);
      check("stall_cycles", 32'(cyc), 32'd37);

      // Async reset mid-stream at beat 12
      in_vector = make_vec(2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 12; k++) @(negedge clk);
      check("mid_data", 32'(out_data), 32'(elem(2, 12)));
      check("mid_row", 32'(out_row), 32'd3);
      check("mid_col", 32'(out_col), 32'd0);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_data", 32'(out_data), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Fresh frame after reset, then back-to-back reversed frame
      run_frame(0, -1, -1, cyc);
      check("b2b_period", 32'(cyc), 32'd34);
      run_frame(1, -1, -1, cyc);
      check("b2b_cycles", 32'(cyc), 32'd34);

      // Degenerate single-element instance
      vec_d = 8'hA5;
      start_d = 1'b1;
      @(negedge clk);
      start_d = 1'b0;
      vec_d = 8'h3C;
      check("deg_valid", 32'(valid_d), 32'd1);
      check("deg_data", 32'(data_d), 32'hA5);
      check("deg_ch", 32'(ch_d), 32'd0);
      check("deg_row", 32'(row_d), 32'd0);
      check("deg_col", 32'(col_d), 32'd0);
      check("deg_last", 32'(last_d), 32'd1);
      check("deg_busy", 32'(busy_d), 32'd1);
      @(negedge clk);
      check("deg_done", 32'(done_d), 32'd1);
      check("deg_valid_off", 32'(valid_d), 32'd0);
      check("deg_last_off", 32'(last_d), 32'd0);
      @(negedge clk);
      check("deg_done_off", 32'(done_d), 32'd0);
      check("deg_busy_off", 32'(busy_d), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
